// File: rtl/adc_filter_chain.sv
`default_nettype none
// ============================================================================
// Module   : adc_filter_chain
// Brief    : 8-tap low-pass FIR, quarter-wave sine/cosine generator and
//            ADC ready/valid enable unit sharing one clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module adc_filter_chain #(
    parameter int PHASE_DIV   = 1,
    parameter int BUSY_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [4:0]        data_in,
    output logic [4:0]        data_out,
    output logic signed [4:0] sine_out,
    output logic signed [4:0] cosine_out,
    input  logic              valid_ADC,
    output logic              ready_ADC,
    output logic              sample_strobe
);

    // ------------------------------------------------------------------ FIR
    logic [4:0]  taps_q [8];
    logic [4:0]  data_out_q;
    logic [4:0]  data_out_d;
    logic [10:0] fir_acc;

    function automatic logic [3:0] fir_coef(input int k);
        case (k)
            0, 7:    fir_coef = 4'd1;
            1, 6:    fir_coef = 4'd2;
            2, 5:    fir_coef = 4'd4;
            default: fir_coef = 4'd9;
        endcase
    endfunction

    always_comb begin
        fir_acc = '0;
        for (int k = 0; k < 8; k++) begin
            fir_acc = fir_acc + 11'(fir_coef(k)) * 11'(taps_q[k]);
        end
        data_out_d = (fir_acc[10:5] > 6'd31) ? 5'd31 : fir_acc[9:5];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 8; k++) taps_q[k] <= '0;
            data_out_q <= '0;
        end else begin
            taps_q[0] <= data_in;
            for (int k = 1; k < 8; k++) taps_q[k] <= taps_q[k-1];
            data_out_q <= data_out_d;
        end
    end

    // ------------------------------------------------------------ generator
    logic [15:0]        div_q;
    logic [15:0]        div_d;
    logic [4:0]         phase_q;
    logic [4:0]         phase_d;
    logic signed [4:0]  sine_q;
    logic signed [4:0]  cosine_q;

    function automatic logic [3:0] quarter_mag(input logic [3:0] idx);
        case (idx)
            4'd0:    quarter_mag = 4'd0;
            4'd1:    quarter_mag = 4'd3;
            4'd2:    quarter_mag = 4'd6;
            4'd3:    quarter_mag = 4'd8;
            4'd4:    quarter_mag = 4'd11;
            4'd5:    quarter_mag = 4'd12;
            4'd6:    quarter_mag = 4'd14;
            default: quarter_mag = 4'd15;
        endcase
    endfunction

    // Odd quarters mirror the index, the second half negates the magnitude.
    function automatic logic signed [4:0] sine_lut(input logic [4:0] k);
        logic [3:0] idx;
        logic [4:0] mag;
        idx = k[3] ? (4'd8 - {1'b0, k[2:0]}) : {1'b0, k[2:0]};
        mag = {1'b0, quarter_mag(idx)};
        sine_lut = k[4] ? $signed(-mag) : $signed(mag);
    endfunction

    always_comb begin
        phase_d = phase_q;
        div_d   = div_q + 16'd1;
        if (div_q == 16'(PHASE_DIV - 1)) begin
            div_d   = '0;
            phase_d = phase_q + 5'd1;
        end
    end

    // Outputs are looked up from the next phase so they always match phase_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q    <= '0;
            phase_q  <= '0;
            sine_q   <= 5'sd0;
            cosine_q <= 5'sd15;
        end else begin
            div_q    <= div_d;
            phase_q  <= phase_d;
            sine_q   <= sine_lut(phase_d);
            cosine_q <= sine_lut(phase_d + 5'd8);
        end
    end

    // ---------------------------------------------------------- enable unit
    typedef enum logic {
        ST_READY = 1'b0,
        ST_BUSY  = 1'b1
    } hs_state_t;

    hs_state_t  state_q;
    logic [7:0] busy_cnt_q;
    logic       ready_q;
    logic       strobe_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_READY;
            busy_cnt_q <= '0;
            ready_q    <= 1'b1;
            strobe_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                ST_READY: begin
                    if (valid_ADC) begin
                        state_q    <= ST_BUSY;
                        busy_cnt_q <= 8'(BUSY_CYCLES);
                        ready_q    <= 1'b0;
                        strobe_q   <= 1'b1;
                    end
                end
                default: begin
                    busy_cnt_q <= busy_cnt_q - 8'd1;
                    if (busy_cnt_q <= 8'd1) begin
                        busy_cnt_q <= '0;
                        state_q    <= ST_READY;
                        ready_q    <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign data_out      = data_out_q;
    assign sine_out      = sine_q;
    assign cosine_out    = cosine_q;
    assign ready_ADC     = ready_q;
    assign sample_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_filter_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_filter_chain
// Brief    : Directed plus randomized bench against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_filter_chain;

    localparam int PHASE_DIV   = 1;
    localparam int BUSY_CYCLES = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic [4:0]        data_in;
    logic [4:0]        data_out;
    logic signed [4:0] sine_out;
    logic signed [4:0] cosine_out;
    logic              valid_ADC;
    logic              ready_ADC;
    logic              sample_strobe;

    int checks   = 0;
    int failures = 0;

    int hist [8];
    int cyc;
    int busy_left;
    int exp_fir;
    int exp_strobe;
    int coef [8] = '{1, 2, 4, 9, 9, 4, 2, 1};

    adc_filter_chain #(
        .PHASE_DIV   (PHASE_DIV),
        .BUSY_CYCLES (BUSY_CYCLES)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .data_in       (data_in),
        .data_out      (data_out),
        .sine_out      (sine_out),
        .cosine_out    (cosine_out),
        .valid_ADC     (valid_ADC),
        .ready_ADC     (ready_ADC),
        .sample_strobe (sample_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int lut(input int k);
        real s;
        s = 15.0 * $sin(2.0 * 3.14159265358979 * k / 32.0);
        if (s >= 0.0) return $rtoi(s + 0.5);
        return -$rtoi(-s + 0.5);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) hist[i] = 0;
        cyc        = 0;
        busy_left  = 0;
        exp_fir    = 0;
        exp_strobe = 0;
    endtask

    task automatic model_edge(input int d, input bit v);
        int acc;
        acc = 0;
        for (int i = 0; i < 8; i++) acc += coef[i] * hist[i];
        exp_fir = (acc / 32 > 31) ? 31 : acc / 32;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
        cyc++;
        if (busy_left == 0) begin
            exp_strobe = v ? 1 : 0;
            if (v) busy_left = BUSY_CYCLES;
        end else begin
            exp_strobe = 0;
            busy_left--;
        end
    endtask

    task automatic check_all();
        int p;
        p = (cyc / PHASE_DIV) % 32;
        chk("data_out", {27'd0, data_out}, exp_fir);
        chk("sine", 32'($signed(sine_out)), lut(p));
        chk("cosine", 32'($signed(cosine_out)), lut((p + 8) % 32));
        chk("ready", {31'd0, ready_ADC}, (busy_left == 0) ? 1 : 0);
        chk("strobe", {31'd0, sample_strobe}, exp_strobe);
    endtask

    task automatic chk_reset();
        chk("rst_data_out", {27'd0, data_out}, 0);
        chk("rst_sine", 32'($signed(sine_out)), 0);
        chk("rst_cosine", 32'($signed(cosine_out)), 15);
        chk("rst_ready", {31'd0, ready_ADC}, 1);
        chk("rst_strobe", {31'd0, sample_strobe}, 0);
    endtask

    task automatic tick(input logic [4:0] d, input logic v);
        data_in   = d;
        valid_ADC = v;
        @(posedge clk);
        model_edge(int'(d), v);
        #1;
        check_all();
    endtask

    // Called at posedge+1: reset asserts mid-cycle, releases on the falling edge.
    task automatic mid_reset();
        #2 resetn = 1'b0;
        #1 chk_reset();
        model_reset();
        #1 resetn = 1'b1;
    endtask

    int dirac_exp [9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    int step_exp  [9]  = '{0, 0, 2, 6, 15, 24, 28, 30, 31};
    int sine_exp  [10] = '{3, 6, 8, 11, 12, 14, 15, 15, 15, 14};
    int strobes;

    initial begin
        resetn    = 1'b0;
        data_in   = '0;
        valid_ADC = 1'b0;
        model_reset();
        #12 chk_reset();
        #1 resetn = 1'b1;

        // Dirac response and the first sine samples after reset
        for (int i = 0; i < 11; i++) begin
            tick((i < 2) ? 5'd3 : 5'd0, 1'b0);
            if (i >= 1 && i <= 9) chk("dirac", {27'd0, data_out}, dirac_exp[i-1]);
            if (i < 10) chk("sine_seq", 32'($signed(sine_out)), sine_exp[i]);
        end
        repeat (4) tick(5'd0, 1'b0);

        // Step response, including saturation hold at 31
        for (int i = 0; i < 12; i++) begin
            tick(5'd31, 1'b0);
            chk("step", {27'd0, data_out}, (i < 9) ? step_exp[i] : 31);
        end

        // Single valid pulse: one strobe, ready low for BUSY_CYCLES cycles
        tick(5'd0, 1'b1);
        chk("pulse_strobe", {31'd0, sample_strobe}, 1);
        for (int i = 0; i < 5; i++) begin
            tick(5'd0, 1'b0);
            chk("pulse_ready", {31'd0, ready_ADC}, (i < 3) ? 0 : 1);
        end

        // Valid held high: one strobe per BUSY_CYCLES+1 clocks
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick(5'($urandom_range(0, 31)), 1'b1);
            if (sample_strobe) strobes++;
        end
        chk("held_strobes", strobes, 4);

        // Randomized traffic, long enough to wrap the phase several times
        for (int i = 0; i < 300; i++)
            tick(5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));

        // Reset in the middle of a step; the step and sine restart from scratch
        repeat (8) tick(5'd0, 1'b0);
        repeat (4) tick(5'd31, 1'b0);
        mid_reset();
        for (int i = 0; i < 12; i++) begin
            tick(5'd31, 1'b0);
            chk("step_after_rst", {27'd0, data_out}, (i < 9) ? step_exp[i] : 31);
            if (i < 10) chk("sine_after_rst", 32'($signed(sine_out)), sine_exp[i]);
        end

        // Reset during random traffic with the handshake likely busy
        for (int i = 0; i < 37; i++)
            tick(5'($urandom_range(0, 31)), 1'b1);
        mid_reset();
        for (int i = 0; i < 10; i++) begin
            tick(5'($urandom_range(0, 31)), ($urandom_range(0, 1) == 0));
            chk("sine_after_rst2", 32'($signed(sine_out)), sine_exp[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_filter_chain.md
ADC_FILTER_CHAIN -- requirements
Module: adc_filter_chain

Interface
REQ-001 Parameter PHASE_DIV, default 1: clock cycles per phase-accumulator step of the sine/cosine generator (range 1..65535).
REQ-002 Parameter BUSY_CYCLES, default 4: cycles ready_ADC stays low after an accepted ADC handshake (range 1..255).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  5  unsigned ADC sample into the low-pass FIR.
REQ-006 data_out  output  5  unsigned filtered sample, registered.
REQ-007 sine_out  output  5  signed two's-complement sine sample, registered.
REQ-008 cosine_out  output  5  signed two's-complement cosine sample, registered.
REQ-009 valid_ADC  input  1  ADC asserts "sample available".
REQ-010 ready_ADC  output  1  block ready to accept an ADC sample, registered.
REQ-011 sample_strobe  output  1  one-cycle pulse marking an accepted ADC handshake, registered.

Function -- filter unit
REQ-012 The filter SHALL be an 8-tap FIR, taps t0..t7 (5-bit unsigned), coefficients c0..c7 = 1,2,4,9,9,4,2,1 (sum 32).
REQ-013 Every rising edge, the filter SHALL shift taps (t0<=data_in, tk<=t(k-1)) and SHALL load data_out with (sum ck*tk using pre-shift taps) >> 5.
REQ-014 The accumulator SHALL be at least 10 bits unsigned, with no overflow; the result SHALL be clamped to 31 if above 31.
REQ-015 Latency: a data_in value sampled at edge n SHALL first affect data_out after edge n+1 (weight c0).
REQ-016 The filter SHALL run every clock regardless of valid_ADC/ready_ADC.

Function -- generator unit (fsm)
REQ-017 A 5-bit phase counter p SHALL increment modulo 32 once every PHASE_DIV clocks, via a divider counter that wraps at PHASE_DIV-1.
REQ-018 sine_out SHALL be registered from LUT(p), LUT(k) = round-half-away-from-zero(15*sin(2*pi*k/32)); first quarter k=0..8: 0,3,6,8,11,12,14,15,15; the other quarters follow by sine symmetry.
REQ-019 cosine_out SHALL be LUT((p+8) mod 32), updated on the same edge as sine_out.
REQ-020 Phase wrap 31->0 SHALL be seamless, without a repeated or skipped sample.

Function -- enable unit (handshake FSM)
REQ-021 States: READY (ready_ADC=1) and BUSY (ready_ADC=0).
REQ-022 In READY with valid_ADC=1 at an edge: sample_strobe=1 for exactly that next cycle, move to BUSY, load busy counter with BUSY_CYCLES.
REQ-023 In BUSY: the counter SHALL decrement each edge and the unit SHALL return to READY once it reaches 0; valid_ADC SHALL be ignored in BUSY.
REQ-024 valid_ADC held high continuously SHALL yield one strobe per READY entry, i.e. one per BUSY_CYCLES+1 clocks.

Reset
REQ-025 While resetn=0, regardless of clk: taps=0, data_out=0, p=0, divider=0, sine_out=0, cosine_out=15, state=READY, ready_ADC=1, sample_strobe=0, busy counter=0.
REQ-026 Reset assertion mid-operation SHALL clear all state immediately; the first update SHALL occur on the first rising edge after resetn rises.

Verification
REQ-027 Dirac: data_in=3 for 2 clocks, then 0 -> data_out=0,0,0,1,1,1,0,0,0 on successive cycles, then 0.
REQ-028 Step: data_in 0->31 held -> data_out=0,0,2,6,15,24,28,30,31, then stays 31.
REQ-029 Generator, PHASE_DIV=1: after reset sine_out=0, cosine_out=15; sine_out sequence 3,6,8,11,12,14,15,15,15,14,... and period 32 clocks, cosine leading sine by 8 samples.
REQ-030 Handshake, BUSY_CYCLES=4: valid_ADC pulse -> one-cycle sample_strobe, ready_ADC low 4 cycles then high; valid_ADC held high -> strobe every 5 clocks.
REQ-031 Reset mid-run: assert resetn=0 during step and sine tests -> all outputs at REQ-025 values immediately, sequences restart from the beginning after release.
